pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Program-counter register and instruction-fetch sequencer for the RISC-V core. Holds the architectural PC, drives it to the PC+4 adder (`Pc_Out`), and takes the incremented value back (`Pc_Add_In`) as the sequential next PC. Issues one-outstanding fetch requests to instruction memory over a valid/ready request channel plus a response strobe. Delivers each fetched word to decode over a valid/ready handshake; branch/jump redirects from execute squash in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `Clk` input 1: single clock; all state updates on rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `Pc_Out` output 32: current PC register, fed to the PC+4 adder.
- `Pc_Add_In` input 32: PC+4 result returned from the adder.
- `Redirect_Valid` input 1: branch/jump taken this cycle.
- `Redirect_Target` input 32: new PC when `Redirect_Valid`=1.
- `Imem_Req_Valid` output 1: fetch request valid.
- `Imem_Req_Ready` input 1: memory accepts request.
- `Imem_Req_Addr` output 32: fetch address, equal to `Pc_Out`.
- `Imem_Rsp_Valid` input 1: response data valid (one-cycle strobe).
- `Imem_Rsp_Data` input 32: fetched instruction word.
- `Inst_Valid` output 1: `Inst_Out`/`Inst_Pc` valid for decode.
- `Inst_Ready` input 1: decode accepts instruction.
- `Inst_Out` output 32: buffered instruction.
- `Inst_Pc` output 32: PC of `Inst_Out`.
- `Misaligned_Err` output 1: one-cycle pulse, redirect target had bits [1:0] ≠ 0.

## Operation
- States: IDLE, REQ, WAIT, DRAIN, HOLD.
- Reset: state IDLE; `Pc_Out`=RESET_PC; `Inst_Out`, `Inst_Pc` = 0; `Imem_Req_Valid`, `Inst_Valid`, `Misaligned_Err` = 0.
- `Imem_Req_Valid` = (state==REQ). `Inst_Valid` = (state==HOLD). `Imem_Req_Addr` = `Pc_Out`.
- IDLE → REQ unconditionally. A redirect in IDLE loads the PC and still goes to REQ.
- REQ:
  - Redirect without handshake: PC ← target; stay REQ. The address changes; this is the only legal change of `Imem_Req_Addr` while valid.
  - Handshake (`Imem_Req_Valid`&`Imem_Req_Ready`) without redirect: → WAIT.
  - Handshake with redirect: old address is consumed; PC ← target; → DRAIN.
- WAIT:
  - `Imem_Rsp_Valid` without redirect: `Inst_Out` ← data; `Inst_Pc` ← `Pc_Out`; PC ← `Pc_Add_In`; → HOLD.
  - Redirect without response: PC ← target; → DRAIN.
  - Redirect with response: response discarded; PC ← target; → REQ.
- DRAIN:
  - `Imem_Rsp_Valid`: response discarded; → REQ.
  - Redirect: PC ← target; stay DRAIN.
  - Redirect with response: PC ← target; → REQ.
- HOLD:
  - Without redirect, `Inst_Ready`=1 → REQ; otherwise hold all outputs stable.
  - Redirect: PC ← target; → REQ.
  - Redirect and `Inst_Ready` in the same cycle: the transfer counts as delivered. Decode/execute flush it.
- Redirect priority: a redirect always overrides the sequential PC update.
- Target alignment: PC ← {target[31:2], 2'b00}. If target[1:0] ≠ 0, `Misaligned_Err`=1 in the following cycle only.
- `Imem_Rsp_Valid` is ignored in IDLE, REQ and HOLD.
- Arithmetic: all 32-bit, unsigned. Wrap-around from 0xFFFF_FFFC to 0x0000_0000 comes naturally from the adder and needs no special handling.
- `Rst` in any state, including WAIT/DRAIN with an outstanding request, returns to the reset values. The memory subsystem is reset on the same `Rst`, so no stale response follows.

## Timing
- Cycle 0 = first cycle with `Rst`=0: state IDLE. Cycle 1: `Imem_Req_Valid`=1, addr=RESET_PC.
- With `Imem_Req_Ready`=1 and response one cycle after acceptance:
  - Handshake at cycle 1.
  - Response at cycle 2.
  - `Inst_Valid`=1 at cycle 3.
  - With `Inst_Ready`=1, next request at cycle 4.
- Steady-state throughput: one instruction per 3 cycles.
- The PC advances in the cycle after the response edge: `Pc_Out` shows PC+4 in HOLD.
- Redirect to new request: the REQ state with the target address appears the next cycle from REQ/WAIT-with-rsp/HOLD, or after the discarded response when starting from DRAIN.
- At most one memory request outstanding.

## Test plan
- Reset, RESET_PC=0x100, memory always ready, 1-cycle latency → requests at 0x100, 0x104, 0x108; `Inst_Pc` matches each; `Inst_Valid` first at cycle 3.
- `Inst_Ready` held 0 for 5 cycles in HOLD → `Inst_Valid`, `Inst_Out`, `Inst_Pc` stable; no new `Imem_Req_Valid`; release → next request at PC+4.
- Redirect to 0x200 in WAIT with response 2 cycles later → response discarded; `Inst_Valid` never asserts for the old word; next request addr 0x200.
- Redirect to 0x300 in the same cycle as `Imem_Rsp_Valid` → data discarded; next cycle REQ at 0x300.
- Redirect target 0x403 → request addr 0x400; `Misaligned_Err` high exactly one cycle.
- PC 0xFFFF_FFFC fetched → next request addr 0x0000_0000. Separately, `Rst` asserted in WAIT → next cycle all outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : Architectural PC register and single-outstanding instruction
//             fetch sequencer. Issues fetch requests, buffers the returned
//             word for decode and applies branch/jump redirects, squashing
//             any fetch that is still in flight.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,

    // PC+4 adder loop
    output logic [31:0] Pc_Out,
    input  logic [31:0] Pc_Add_In,

    // Redirect from execute
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,

    // Instruction memory request / response
    output logic        Imem_Req_Valid,
    input  logic        Imem_Req_Ready,
    output logic [31:0] Imem_Req_Addr,
    input  logic        Imem_Rsp_Valid,
    input  logic [31:0] Imem_Rsp_Data,

    // Decode interface
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    output logic [31:0] Inst_Out,
    output logic [31:0] Inst_Pc,

    // Redirect target had non-zero low bits (pulse, one cycle late)
    output logic        Misaligned_Err
);

    // IDLE : first cycle out of reset, nothing outstanding
    // REQ  : request presented to memory
    // WAIT : request accepted, response pending and still wanted
    // DRAIN: request accepted, response pending but squashed by a redirect
    // HOLD : fetched word buffered, offered to decode
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        mis_q, mis_d;

    logic [31:0] redir_pc;
    logic        req_hs;

    // Redirect targets are forced to word alignment; the low bits only
    // feed the error pulse.
    assign redir_pc = {Redirect_Target[31:2], 2'b00};
    assign req_hs   = (state_q == ST_REQ) && Imem_Req_Ready;

    // State, PC, instruction buffer and error pulse registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            mis_q     <= mis_d;
        end
    end

    // Next-state, PC selection and instruction capture
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        mis_d     = Redirect_Valid && (Redirect_Target[1:0] != 2'b00);

        unique case (state_q)
            ST_IDLE: begin
                if (Redirect_Valid) begin
                    pc_d = redir_pc;
                end
                state_d = ST_REQ;
            end

            ST_REQ: begin
                // A redirect may retarget a pending request; once the
                // handshake happens the old address is already consumed
                // and its response must be drained.
                if (Redirect_Valid) begin
                    pc_d    = redir_pc;
                    state_d = req_hs ? ST_DRAIN : ST_REQ;
                end else if (req_hs) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (Redirect_Valid) begin
                    pc_d    = redir_pc;
                    // Response arriving with the redirect is dropped here,
                    // so nothing is left outstanding.
                    state_d = Imem_Rsp_Valid ? ST_REQ : ST_DRAIN;
                end else if (Imem_Rsp_Valid) begin
                    inst_d    = Imem_Rsp_Data;
                    inst_pc_d = pc_q;
                    pc_d      = Pc_Add_In;
                    state_d   = ST_HOLD;
                end
            end

            ST_DRAIN: begin
                if (Redirect_Valid) begin
                    pc_d = redir_pc;
                end
                if (Imem_Rsp_Valid) begin
                    state_d = ST_REQ;
                end
            end

            ST_HOLD: begin
                // A redirect alongside Inst_Ready still counts the word as
                // delivered; downstream flushes it.
                if (Redirect_Valid) begin
                    pc_d    = redir_pc;
                    state_d = ST_REQ;
                end else if (Inst_Ready) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Pc_Out         = pc_q;
    assign Imem_Req_Addr  = pc_q;
    assign Imem_Req_Valid = (state_q == ST_REQ);
    assign Inst_Valid     = (state_q == ST_HOLD);
    assign Inst_Out       = inst_q;
    assign Inst_Pc        = inst_pc_q;
    assign Misaligned_Err = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_ctrl
//  Purpose  : Directed self-checking bench for pc_fetch_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        Clk;
    logic        Rst;
    logic [31:0] Pc_Out;
    logic [31:0] Pc_Add_In;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        Imem_Req_Valid;
    logic        Imem_Req_Ready;
    logic [31:0] Imem_Req_Addr;
    logic        Imem_Rsp_Valid;
    logic [31:0] Imem_Rsp_Data;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Inst_Out;
    logic [31:0] Inst_Pc;
    logic        Misaligned_Err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Pc_Out          (Pc_Out),
        .Pc_Add_In       (Pc_Add_In),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .Imem_Req_Valid  (Imem_Req_Valid),
        .Imem_Req_Ready  (Imem_Req_Ready),
        .Imem_Req_Addr   (Imem_Req_Addr),
        .Imem_Rsp_Valid  (Imem_Rsp_Valid),
        .Imem_Rsp_Data   (Imem_Rsp_Data),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Inst_Out        (Inst_Out),
        .Inst_Pc         (Inst_Pc),
        .Misaligned_Err  (Misaligned_Err)
    );

    // External PC+4 adder
    assign Pc_Add_In = Pc_Out + 32'd4;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Advance one clock; outputs are then sampled and inputs driven 1 ns
    // after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        step();
        step();
        chk_cnt++; if (Pc_Out !== 32'h100) $display("FAIL reset_pc: got %h want %h", Pc_Out, 32'h100); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Inst_Valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", Inst_Valid); else pass_cnt++;
        chk_cnt++; if (Inst_Out !== 32'h0) $display("FAIL reset_inst_out: got %h want 0", Inst_Out); else pass_cnt++;
        chk_cnt++; if (Inst_Pc !== 32'h0) $display("FAIL reset_inst_pc: got %h want 0", Inst_Pc); else pass_cnt++;
        chk_cnt++; if (Misaligned_Err !== 1'b0) $display("FAIL reset_mis: got %b want 0", Misaligned_Err); else pass_cnt++;
        Rst = 1'b0;
        // cycle 0: IDLE
        chk_cnt++; if (Imem_Req_Valid !== 1'b0) $display("FAIL cyc0_req_valid: got %b want 0", Imem_Req_Valid); else pass_cnt++;
    endtask

    // Three back-to-back fetches at 0x100, 0x104, 0x108 with ready memory
    task automatic test_sequential();
        logic [31:0] data;
        step(); // cycle 1
        chk_cnt++; if (Imem_Req_Valid !== 1'b1) $display("FAIL cyc1_req_valid: got %b want 1", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h100) $display("FAIL cyc1_req_addr: got %h want %h", Imem_Req_Addr, 32'h100); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            data = 32'hA000_0000 + i;
            step(); // WAIT
            chk_cnt++; if (Inst_Valid !== 1'b0) $display("FAIL seq%0d_wait_inst_valid: got %b want 0", i, Inst_Valid); else pass_cnt++;
            Imem_Rsp_Valid = 1'b1;
            Imem_Rsp_Data  = data;
            step(); // HOLD
            Imem_Rsp_Valid = 1'b0;
            chk_cnt++; if (Inst_Valid !== 1'b1) $display("FAIL seq%0d_inst_valid: got %b want 1", i, Inst_Valid); else pass_cnt++;
            chk_cnt++; if (Inst_Out !== data) $display("FAIL seq%0d_inst_out: got %h want %h", i, Inst_Out, data); else pass_cnt++;
            chk_cnt++; if (Inst_Pc !== 32'h100 + 4*i) $display("FAIL seq%0d_inst_pc: got %h want %h", i, Inst_Pc, 32'h100 + 4*i); else pass_cnt++;
            chk_cnt++; if (Pc_Out !== 32'h104 + 4*i) $display("FAIL seq%0d_pc_hold: got %h want %h", i, Pc_Out, 32'h104 + 4*i); else pass_cnt++;
            step(); // REQ
            chk_cnt++; if (Imem_Req_Valid !== 1'b1) $display("FAIL seq%0d_next_req: got %b want 1", i, Imem_Req_Valid); else pass_cnt++;
            chk_cnt++; if (Imem_Req_Addr !== 32'h104 + 4*i) $display("FAIL seq%0d_next_addr: got %h want %h", i, Imem_Req_Addr, 32'h104 + 4*i); else pass_cnt++;
        end
    endtask

    // Decode stalls 5 cycles in HOLD; entered from REQ at 0x10C
    task automatic test_hold_stall();
        step(); // WAIT
        Imem_Rsp_Valid = 1'b1;
        Imem_Rsp_Data  = 32'h1234_5678;
        step(); // HOLD
        Imem_Rsp_Valid = 1'b0;
        Inst_Ready     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (Inst_Valid !== 1'b1) $display("FAIL stall%0d_inst_valid: got %b want 1", i, Inst_Valid); else pass_cnt++;
            chk_cnt++; if (Inst_Out !== 32'h1234_5678) $display("FAIL stall%0d_inst_out: got %h want 12345678", i, Inst_Out); else pass_cnt++;
            chk_cnt++; if (Inst_Pc !== 32'h10C) $display("FAIL stall%0d_inst_pc: got %h want 0000010c", i, Inst_Pc); else pass_cnt++;
            chk_cnt++; if (Imem_Req_Valid !== 1'b0) $display("FAIL stall%0d_req_valid: got %b want 0", i, Imem_Req_Valid); else pass_cnt++;
            step();
        end
        chk_cnt++; if (Inst_Valid !== 1'b1) $display("FAIL stall_end_inst_valid: got %b want 1", Inst_Valid); else pass_cnt++;
        Inst_Ready = 1'b1;
        step(); // REQ
        chk_cnt++; if (Imem_Req_Valid !== 1'b1) $display("FAIL stall_rel_req_valid: got %b want 1", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h110) $display("FAIL stall_rel_addr: got %h want 00000110", Imem_Req_Addr); else pass_cnt++;
    endtask

    // Redirect in WAIT, stale response two cycles later; from REQ at 0x110
    task automatic test_redirect_wait();
        step(); // WAIT
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h200;
        step(); // DRAIN
        Redirect_Valid  = 1'b0;
        chk_cnt++; if (Pc_Out !== 32'h200) $display("FAIL rw_pc: got %h want 00000200", Pc_Out); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Valid !== 1'b0) $display("FAIL rw_drain_req: got %b want 0", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Inst_Valid !== 1'b0) $display("FAIL rw_drain_inst1: got %b want 0", Inst_Valid); else pass_cnt++;
        step(); // still DRAIN
        chk_cnt++; if (Inst_Valid !== 1'b0) $display("FAIL rw_drain_inst2: got %b want 0", Inst_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Valid !== 1'b0) $display("FAIL rw_drain_req2: got %b want 0", Imem_Req_Valid); else pass_cnt++;
        Imem_Rsp_Valid = 1'b1;
        Imem_Rsp_Data  = 32'hDEAD_BEEF;
        step(); // REQ
        Imem_Rsp_Valid = 1'b0;
        chk_cnt++; if (Inst_Valid !== 1'b0) $display("FAIL rw_inst_valid: got %b want 0", Inst_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Valid !== 1'b1) $display("FAIL rw_req_valid: got %b want 1", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h200) $display("FAIL rw_req_addr: got %h want 00000200", Imem_Req_Addr); else pass_cnt++;
    endtask

    // Redirect coincident with response; from REQ at 0x200
    task automatic test_redirect_rsp();
        step(); // WAIT
        Imem_Rsp_Valid  = 1'b1;
        Imem_Rsp_Data   = 32'hBAD0_BAD0;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h300;
        step(); // REQ
        Imem_Rsp_Valid  = 1'b0;
        Redirect_Valid  = 1'b0;
        chk_cnt++; if (Imem_Req_Valid !== 1'b1) $display("FAIL rr_req_valid: got %b want 1", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h300) $display("FAIL rr_req_addr: got %h want 00000300", Imem_Req_Addr); else pass_cnt++;
        chk_cnt++; if (Inst_Valid !== 1'b0) $display("FAIL rr_inst_valid: got %b want 0", Inst_Valid); else pass_cnt++;
        chk_cnt++; if (Misaligned_Err !== 1'b0) $display("FAIL rr_mis: got %b want 0", Misaligned_Err); else pass_cnt++;
    endtask

    // Misaligned redirect while a request waits for ready; from REQ at 0x300
    task automatic test_misaligned();
        Imem_Req_Ready  = 1'b0;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h403;
        step(); // REQ retargeted
        Redirect_Valid  = 1'b0;
        chk_cnt++; if (Imem_Req_Valid !== 1'b1) $display("FAIL mis_req_valid: got %b want 1", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h400) $display("FAIL mis_addr: got %h want 00000400", Imem_Req_Addr); else pass_cnt++;
        chk_cnt++; if (Misaligned_Err !== 1'b1) $display("FAIL mis_pulse: got %b want 1", Misaligned_Err); else pass_cnt++;
        step();
        chk_cnt++; if (Misaligned_Err !== 1'b0) $display("FAIL mis_pulse_end: got %b want 0", Misaligned_Err); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h400) $display("FAIL mis_addr_hold: got %h want 00000400", Imem_Req_Addr); else pass_cnt++;
        Imem_Req_Ready = 1'b1;
    endtask

    // Fetch at 0xFFFF_FFFC wraps to 0; from REQ at 0x400 with ready
    task automatic test_wrap();
        step(); // WAIT
        Imem_Rsp_Valid  = 1'b1;
        Imem_Rsp_Data   = 32'h0;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'hFFFF_FFFC;
        step(); // REQ at FFFFFFFC
        Imem_Rsp_Valid  = 1'b0;
        Redirect_Valid  = 1'b0;
        chk_cnt++; if (Imem_Req_Addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req_addr: got %h want fffffffc", Imem_Req_Addr); else pass_cnt++;
        step(); // WAIT
        Imem_Rsp_Valid = 1'b1;
        Imem_Rsp_Data  = 32'h0000_0013;
        step(); // HOLD
        Imem_Rsp_Valid = 1'b0;
        chk_cnt++; if (Inst_Pc !== 32'hFFFF_FFFC) $display("FAIL wrap_inst_pc: got %h want fffffffc", Inst_Pc); else pass_cnt++;
        chk_cnt++; if (Pc_Out !== 32'h0) $display("FAIL wrap_pc: got %h want 00000000", Pc_Out); else pass_cnt++;
        step(); // REQ at 0
        chk_cnt++; if (Imem_Req_Valid !== 1'b1) $display("FAIL wrap_next_valid: got %b want 1", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h0) $display("FAIL wrap_next_addr: got %h want 00000000", Imem_Req_Addr); else pass_cnt++;
    endtask

    // Redirect together with Inst_Ready in HOLD; from REQ at 0x0
    task automatic test_redirect_hold();
        step(); // WAIT
        Imem_Rsp_Valid = 1'b1;
        Imem_Rsp_Data  = 32'h5555_AAAA;
        step(); // HOLD
        Imem_Rsp_Valid = 1'b0;
        chk_cnt++; if (Inst_Out !== 32'h5555_AAAA) $display("FAIL rh_inst_out: got %h want 5555aaaa", Inst_Out); else pass_cnt++;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h500;
        step(); // REQ at 0x500
        Redirect_Valid  = 1'b0;
        chk_cnt++; if (Inst_Valid !== 1'b0) $display("FAIL rh_inst_valid: got %b want 0", Inst_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h500) $display("FAIL rh_req_addr: got %h want 00000500", Imem_Req_Addr); else pass_cnt++;
    endtask

    // Reset asserted with a request outstanding; from REQ at 0x500
    task automatic test_reset_in_wait();
        step(); // WAIT
        Rst = 1'b1;
        step();
        chk_cnt++; if (Pc_Out !== 32'h100) $display("FAIL rstw_pc: got %h want 00000100", Pc_Out); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Valid !== 1'b0) $display("FAIL rstw_req_valid: got %b want 0", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Inst_Valid !== 1'b0) $display("FAIL rstw_inst_valid: got %b want 0", Inst_Valid); else pass_cnt++;
        chk_cnt++; if (Inst_Out !== 32'h0) $display("FAIL rstw_inst_out: got %h want 0", Inst_Out); else pass_cnt++;
        chk_cnt++; if (Inst_Pc !== 32'h0) $display("FAIL rstw_inst_pc: got %h want 0", Inst_Pc); else pass_cnt++;
        Rst = 1'b0;
        step(); // REQ at RESET_PC
        chk_cnt++; if (Imem_Req_Valid !== 1'b1) $display("FAIL rstw_restart_valid: got %b want 1", Imem_Req_Valid); else pass_cnt++;
        chk_cnt++; if (Imem_Req_Addr !== 32'h100) $display("FAIL rstw_restart_addr: got %h want 00000100", Imem_Req_Addr); else pass_cnt++;
    endtask

    initial begin
        Rst             = 1'b1;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 32'h0;
        Imem_Req_Ready  = 1'b1;
        Imem_Rsp_Valid  = 1'b0;
        Imem_Rsp_Data   = 32'h0;
        Inst_Ready      = 1'b1;

        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_misaligned();
        test_wrap();
        test_redirect_hold();
        test_reset_in_wait();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
